// File: rtl/cmp_debounce_fsm.sv
// Debounces comparator_4bit agb/aeb/alb flags into a hysteretic level with rise/fall/err pulses.
// Optional saturating event counters with a cnt_clr input are enabled by defining CMP_EVT_CNT_EN.
module cmp_debounce_fsm #(
    parameter int DEBOUNCE = 3,
    parameter int DB_W     = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             agb,
    input  logic             aeb,
    input  logic             alb,
    output logic             level,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             err
`ifdef CMP_EVT_CNT_EN
    ,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] rise_cnt,
    output logic [CNT_W-1:0] fall_cnt,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    typedef enum logic [1:0] {S_LOW, S_RISE, S_HIGH, S_FALL} state_t;
    typedef enum logic [1:0] {C_HI, C_LO, C_EQ, C_BAD} cls_t;

    if (DEBOUNCE < 1 || DEBOUNCE > (2**DB_W) - 1 || CNT_W < 1) begin : g_bad_cfg
        $error("cmp_debounce_fsm: illegal DEBOUNCE/DB_W/CNT_W combination");
    end

    state_t          state;
    logic [DB_W-1:0] dbc;
    logic [DB_W-1:0] dbc_inc;
    logic            at_limit;
    cls_t            cls;
    logic            rise_evt;
    logic            fall_evt;
    logic            err_evt;

    // dbc is always 0 in LOW/HIGH, so at_limit also covers the DEBOUNCE==1 direct jump.
    always_comb begin
        unique case ({agb, aeb, alb})
            3'b100:  cls = C_HI;
            3'b001:  cls = C_LO;
            3'b010:  cls = C_EQ;
            default: cls = C_BAD;
        endcase
        dbc_inc  = dbc + DB_W'(1);
        at_limit = (dbc_inc == DB_W'(DEBOUNCE));
        rise_evt = in_valid && (cls == C_HI) && at_limit &&
                   ((state == S_LOW) || (state == S_RISE));
        fall_evt = in_valid && (cls == C_LO) && at_limit &&
                   ((state == S_HIGH) || (state == S_FALL));
        err_evt  = in_valid && (cls == C_BAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_LOW;
            dbc        <= '0;
            level      <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            err        <= 1'b0;
        end else begin
            rise_pulse <= rise_evt;
            fall_pulse <= fall_evt;
            err        <= err_evt;
            if (in_valid) begin
                unique case (state)
                    S_LOW, S_RISE: begin
                        if (cls == C_HI) begin
                            if (at_limit) begin
                                state <= S_HIGH;
                                dbc   <= '0;
                                level <= 1'b1;
                            end else begin
                                state <= S_RISE;
                                dbc   <= dbc_inc;
                            end
                        end else if (cls == C_LO || cls == C_BAD) begin
                            state <= S_LOW;
                            dbc   <= '0;
                        end
                    end
                    S_HIGH, S_FALL: begin
                        if (cls == C_LO) begin
                            if (at_limit) begin
                                state <= S_LOW;
                                dbc   <= '0;
                                level <= 1'b0;
                            end else begin
                                state <= S_FALL;
                                dbc   <= dbc_inc;
                            end
                        end else if (cls == C_HI || cls == C_BAD) begin
                            state <= S_HIGH;
                            dbc   <= '0;
                        end
                    end
                    default: begin
                        state <= S_LOW;
                        dbc   <= '0;
                    end
                endcase
            end
        end
    end

`ifdef CMP_EVT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_cnt <= '0;
            fall_cnt <= '0;
            err_cnt  <= '0;
        end else if (cnt_clr) begin
            rise_cnt <= '0;
            fall_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (rise_evt && rise_cnt != '1) rise_cnt <= rise_cnt + CNT_W'(1);
            if (fall_evt && fall_cnt != '1) fall_cnt <= fall_cnt + CNT_W'(1);
            if (err_evt  && err_cnt  != '1) err_cnt  <= err_cnt  + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_cmp_debounce_fsm.sv
// Bench for cmp_debounce_fsm: vector table, hand-written corner sequences, randomized run vs reference model.
module tb_cmp_debounce_fsm;

    localparam int D     = 3;
    localparam int CW    = 2;
    localparam int CMAX  = (1 << CW) - 1;
    localparam logic [2:0] HI = 3'b100;
    localparam logic [2:0] LO = 3'b001;
    localparam logic [2:0] EQ = 3'b010;

    logic clk, rst_n, in_valid, agb, aeb, alb;
    logic level, rise_pulse, fall_pulse, err;
    logic cnt_clr;
`ifdef CMP_EVT_CNT_EN
    logic [CW-1:0] rise_cnt, fall_cnt, err_cnt;
`endif

    cmp_debounce_fsm #(.DEBOUNCE(D), .DB_W(4), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .agb(agb), .aeb(aeb), .alb(alb),
        .level(level), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .err(err)
`ifdef CMP_EVT_CNT_EN
        , .cnt_clr(cnt_clr), .rise_cnt(rise_cnt), .fall_cnt(fall_cnt), .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: level plus the length of the current run of samples voting for the other level.
    int   run;
    logic m_lvl, m_rise, m_fall, m_err;
    int   m_rc, m_fc, m_ec;

    typedef struct {
        logic       v;
        logic [2:0] f;
        logic       lvl, r, fl, e;
    } vec_t;
    vec_t tbl[31];

    function automatic vec_t mk(logic v, logic [2:0] f, logic l, logic r, logic fl, logic e);
        vec_t t;
        t.v = v; t.f = f; t.lvl = l; t.r = r; t.fl = fl; t.e = e;
        return t;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        run = 0; m_lvl = 0; m_rise = 0; m_fall = 0; m_err = 0;
        m_rc = 0; m_fc = 0; m_ec = 0;
    endtask

    task automatic model_upd(input logic v, input logic [2:0] f, input logic clr);
        m_rise = 0; m_fall = 0; m_err = 0;
        if (v) begin
            if (f == HI) begin
                if (!m_lvl) begin
                    run++;
                    if (run >= D) begin m_lvl = 1; m_rise = 1; run = 0; end
                end else run = 0;
            end else if (f == LO) begin
                if (m_lvl) begin
                    run++;
                    if (run >= D) begin m_lvl = 0; m_fall = 1; run = 0; end
                end else run = 0;
            end else if (f != EQ) begin
                m_err = 1; run = 0;
            end
        end
        if (clr) begin
            m_rc = 0; m_fc = 0; m_ec = 0;
        end else begin
            if (m_rise && m_rc < CMAX) m_rc++;
            if (m_fall && m_fc < CMAX) m_fc++;
            if (m_err  && m_ec < CMAX) m_ec++;
        end
    endtask

    task automatic step(input logic v, input logic [2:0] f);
        in_valid = v; agb = f[2]; aeb = f[1]; alb = f[0];
        @(posedge clk);
        model_upd(v, f, cnt_clr);
        #1;
    endtask

    task automatic do_reset(input string nm);
        rst_n = 0;
        #1;
        model_reset();
        chk({nm, "_level"}, level, 0);
        chk({nm, "_pulses"}, {rise_pulse, fall_pulse, err}, 0);
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        logic [2:0] f;
        logic       v;
        int         r;

        clk = 0; rst_n = 0; in_valid = 0; agb = 0; aeb = 0; alb = 0; cnt_clr = 0;
        model_reset();
        #3;
        chk("reset_level", level, 0);
        chk("reset_pulses", {rise_pulse, fall_pulse, err}, 0);
`ifdef CMP_EVT_CNT_EN
        chk("reset_cnts", {rise_cnt, fall_cnt, err_cnt}, 0);
`endif
        @(posedge clk); #1; rst_n = 1;

        tbl[0]  = mk(1, HI, 0, 0, 0, 0);
        tbl[1]  = mk(1, HI, 0, 0, 0, 0);
        tbl[2]  = mk(1, HI, 1, 1, 0, 0);
        tbl[3]  = mk(1, LO, 1, 0, 0, 0);
        tbl[4]  = mk(1, LO, 1, 0, 0, 0);
        tbl[5]  = mk(1, HI, 1, 0, 0, 0);
        tbl[6]  = mk(1, LO, 1, 0, 0, 0);
        tbl[7]  = mk(1, LO, 1, 0, 0, 0);
        tbl[8]  = mk(1, LO, 0, 0, 1, 0);
        tbl[9]  = mk(1, HI, 0, 0, 0, 0);
        tbl[10] = mk(1, EQ, 0, 0, 0, 0);
        tbl[11] = mk(1, EQ, 0, 0, 0, 0);
        tbl[12] = mk(1, HI, 0, 0, 0, 0);
        tbl[13] = mk(1, HI, 1, 1, 0, 0);
        tbl[14] = mk(1, LO, 1, 0, 0, 0);
        tbl[15] = mk(1, LO, 1, 0, 0, 0);
        tbl[16] = mk(1, LO, 0, 0, 1, 0);
        tbl[17] = mk(1, HI, 0, 0, 0, 0);
        tbl[18] = mk(1, HI, 0, 0, 0, 0);
        tbl[19] = mk(1, 3'b101, 0, 0, 0, 1);
        tbl[20] = mk(1, HI, 0, 0, 0, 0);
        tbl[21] = mk(1, HI, 0, 0, 0, 0);
        tbl[22] = mk(1, HI, 1, 1, 0, 0);
        tbl[23] = mk(0, HI, 1, 0, 0, 0);
        tbl[24] = mk(0, 3'b111, 1, 0, 0, 0);
        tbl[25] = mk(1, 3'b111, 1, 0, 0, 1);
        tbl[26] = mk(1, LO, 1, 0, 0, 0);
        tbl[27] = mk(1, 3'b000, 1, 0, 0, 1);
        tbl[28] = mk(1, LO, 1, 0, 0, 0);
        tbl[29] = mk(1, LO, 1, 0, 0, 0);
        tbl[30] = mk(1, LO, 0, 0, 1, 0);

        for (int i = 0; i < 31; i++) begin
            step(tbl[i].v, tbl[i].f);
            chk($sformatf("vec%0d_level", i), level, tbl[i].lvl);
            chk($sformatf("vec%0d_rise", i), rise_pulse, tbl[i].r);
            chk($sformatf("vec%0d_fall", i), fall_pulse, tbl[i].fl);
            chk($sformatf("vec%0d_err", i), err, tbl[i].e);
        end

        // Idle gaps between valid samples do not disturb the debounce count.
        do_reset("gap_rst");
        for (int k = 0; k < 2; k++) begin
            step(1, HI);
            for (int g = 0; g < 5; g++) begin
                step(0, HI);
                chk("gap_level", level, 0);
                chk("gap_rise", rise_pulse, 0);
            end
        end
        step(1, HI);
        chk("gap_final_level", level, 1);
        chk("gap_final_rise", rise_pulse, 1);
        step(0, HI);
        chk("gap_rise_one_cycle", rise_pulse, 0);

        // Reset mid-fall drops level at once; reset mid-rise restarts the count.
        step(1, LO);
        step(1, LO);
        do_reset("midfall_rst");
        step(1, HI);
        step(1, HI);
        do_reset("midrise_rst");
        step(1, HI);
        chk("after_rst_hi1", level, 0);
        step(1, HI);
        chk("after_rst_hi2", level, 0);
        step(1, HI);
        chk("after_rst_hi3_level", level, 1);
        chk("after_rst_hi3_rise", rise_pulse, 1);

`ifdef CMP_EVT_CNT_EN
        do_reset("cnt_rst");
        chk("cnt_after_rst", {rise_cnt, fall_cnt, err_cnt}, 0);
        for (int i = 0; i < 5; i++) begin
            repeat (3) step(1, HI);
            chk($sformatf("rise_cnt_%0d", i), rise_cnt, (i + 1 > CMAX) ? CMAX : i + 1);
            repeat (3) step(1, LO);
            chk($sformatf("fall_cnt_%0d", i), fall_cnt, (i + 1 > CMAX) ? CMAX : i + 1);
        end
        step(1, 3'b011);
        chk("err_cnt_1", err_cnt, 1);
        step(1, HI);
        step(1, HI);
        cnt_clr = 1;
        step(1, HI);
        cnt_clr = 0;
        chk("clr_rise_pulse", rise_pulse, 1);
        chk("clr_rise_cnt", rise_cnt, 0);
        chk("clr_other_cnts", {fall_cnt, err_cnt}, 0);
        repeat (3) step(1, LO);
        chk("post_clr_fall_cnt", fall_cnt, 1);
`endif

        // Randomized run against the reference model.
        do_reset("rand_rst");
        for (int n = 0; n < 3000; n++) begin
            v = ($urandom_range(0, 9) < 8);
            r = $urandom_range(0, 19);
            if (r < 7) f = HI;
            else if (r < 14) f = LO;
            else if (r < 17) f = EQ;
            else begin
                case ($urandom_range(0, 4))
                    0: f = 3'b000;
                    1: f = 3'b011;
                    2: f = 3'b101;
                    3: f = 3'b110;
                    default: f = 3'b111;
                endcase
            end
`ifdef CMP_EVT_CNT_EN
            cnt_clr = ($urandom_range(0, 49) == 0);
`endif
            step(v, f);
            chk("rand_level", level, m_lvl);
            chk("rand_rise", rise_pulse, m_rise);
            chk("rand_fall", fall_pulse, m_fall);
            chk("rand_err", err, m_err);
`ifdef CMP_EVT_CNT_EN
            chk("rand_rise_cnt", rise_cnt, m_rc);
            chk("rand_fall_cnt", fall_cnt, m_fc);
            chk("rand_err_cnt", err_cnt, m_ec);
`endif
        end
        cnt_clr = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
